// File: rtl/ssd_multiplexer.sv
// ssd_multiplexer: N-digit multiplexed seven-segment display driver.
// A scan prescaler steps through the digits. Display data is double-buffered:
// writes go to a pending register and reach the shadow copy at frame boundaries.
// Each digit has an enable, and all anodes are blanked at the start of each slot.
// Optional feature: define SSD_LZ_BLANK_EN to suppress leading zeros.

module ssd_multiplexer #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned SCAN_DIV     = 262144,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic                    frame_done
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PcntLast = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pcnt_q, pcnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_dg_q, pend_dg_d, sh_dg_q, sh_dg_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, sh_en_q, sh_en_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    slot_end, frame_end, blank;
    logic [3:0]              cur_nib;
    logic                    cur_en, cur_dp, cur_sup;
    logic [NUM_DIGITS-1:0]   cur_hot;
    logic [NUM_DIGITS-1:0]   sup;

    // Active-low segment pattern, [6]=a .. [0]=g; b and d in lowercase form.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            4'hF: s = 7'h38;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Prescaler and digit index; idx wrapping to 0 marks the frame boundary.
    always_comb begin
        slot_end  = (pcnt_q == PcntLast);
        frame_end = slot_end && (idx_q == IdxLast);
        pcnt_d    = slot_end ? '0 : pcnt_q + PW'(1);
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IW'(1);
        end
    end

    // Pending/shadow double buffer; a load on the boundary bypasses pending.
    always_comb begin
        pend_dg_d    = pend_dg_q;
        pend_dp_d    = pend_dp_q;
        pend_en_d    = pend_en_q;
        pend_valid_d = pend_valid_q;
        sh_dg_d      = sh_dg_q;
        sh_dp_d      = sh_dp_q;
        sh_en_d      = sh_en_q;
        if (load) begin
            pend_dg_d    = digits_in;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en_in;
            pend_valid_d = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                sh_dg_d = digits_in;
                sh_dp_d = dp_in;
                sh_en_d = digit_en_in;
            end else if (pend_valid_q) begin
                sh_dg_d = pend_dg_q;
                sh_dp_d = pend_dp_q;
                sh_en_d = pend_en_q;
            end
            pend_valid_d = 1'b0;
        end
    end

`ifdef SSD_LZ_BLANK_EN
    logic lz_run;

    // Walk down from the top digit; stay suppressed while all enabled digits seen are zero.
    always_comb begin
        lz_run = 1'b1;
        sup    = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (sh_en_q[i] && (sh_dg_q[4*i +: 4] != 4'h0)) begin
                lz_run = 1'b0;
            end
            if (i > 0) begin
                sup[i] = lz_run;
            end
        end
    end
`else
    assign sup = '0;
`endif

    // Select the shadow data of the digit currently being scanned.
    always_comb begin
        cur_nib = '0;
        cur_en  = 1'b0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        cur_hot = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (IW'(i) == idx_q) begin
                cur_hot[i] = 1'b1;
                cur_nib    = sh_dg_q[4*i +: 4];
                cur_en     = sh_en_q[i];
                cur_dp     = sh_dp_q[i];
                cur_sup    = sup[i];
            end
        end
    end

    // Next pin values; everything dark during the blanking window or for hidden digits.
    always_comb begin
        blank = (32'(pcnt_q) < BLANK_CYCLES);
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        fd_d  = frame_end;
        if (!blank && cur_en && !cur_sup) begin
            an_d  = ~cur_hot;
            seg_d = hex_to_seg(cur_nib);
            dp_d  = ~cur_dp;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            pend_dg_q    <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_valid_q <= 1'b0;
            sh_dg_q      <= '0;
            sh_dp_q      <= '0;
            sh_en_q      <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            fd_q         <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pend_dg_q    <= pend_dg_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_valid_q <= pend_valid_d;
            sh_dg_q      <= sh_dg_d;
            sh_dp_q      <= sh_dp_d;
            sh_en_q      <= sh_en_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            fd_q         <= fd_d;
        end
    end

    assign an_out     = an_q;
    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_ssd_multiplexer.sv
// tb_ssd_multiplexer: directed and random stimulus against a time-based
// reference model (slot and phase derived from the cycle count since reset).

module tb_ssd_multiplexer;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BL = 2;
    localparam int FR = N * SD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en_in;
    logic        load;
    logic [3:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic        frame_done;

    ssd_multiplexer #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .digit_en_in (digit_en_in),
        .load        (load),
        .an_out      (an_out),
        .seg_out     (seg_out),
        .dp_out      (dp_out),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model state.
    int          t;
    logic [15:0] sh_dg, pd_dg;
    logic [3:0]  sh_dp, sh_en, pd_dp, pd_en;
    bit          pv;

    // Observation tallies for the directed checks.
    int lit [4];
    int fd_seen[$];
    bit seen_a, seen_5;

    function automatic string glyph(input logic [3:0] nib);
        case (nib)
            4'h0: return "abcdef";
            4'h1: return "bc";
            4'h2: return "abdeg";
            4'h3: return "abcdg";
            4'h4: return "bcfg";
            4'h5: return "acdfg";
            4'h6: return "acdefg";
            4'h7: return "abc";
            4'h8: return "abcdefg";
            4'h9: return "abcdfg";
            4'hA: return "abcefg";
            4'hB: return "cdefg";
            4'hC: return "adef";
            4'hD: return "bcdeg";
            4'hE: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    // Active-low code built from the lit segment letters, [6]=a .. [0]=g.
    function automatic logic [6:0] seg_code(input logic [3:0] nib);
        string      s;
        logic [6:0] c;
        s = glyph(nib);
        c = 7'h7F;
        for (int k = 0; k < s.len(); k++) begin
            c[6 - (int'(s[k]) - 97)] = 1'b0;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
        end
    endtask

    task automatic clear_tallies();
        for (int i = 0; i < 4; i++) lit[i] = 0;
        fd_seen.delete();
        seen_a = 0;
        seen_5 = 0;
    endtask

    task automatic model_reset();
        t     = 0;
        sh_dg = '0;
        sh_dp = '0;
        sh_en = '0;
        pd_dg = '0;
        pd_dp = '0;
        pd_en = '0;
        pv    = 0;
    endtask

    // One clock: drive inputs, predict the pins after the edge, update the model, compare.
    task automatic step(input bit ld, input logic [15:0] dg, input logic [3:0] dp,
                        input logic [3:0] en);
        int         slot, ph, msd;
        logic [3:0] nib;
        bit         shown;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        load        = ld;
        digits_in   = dg;
        dp_in       = dp;
        digit_en_in = en;
        slot  = (t / SD) % N;
        ph    = t % SD;
        nib   = sh_dg[4*slot +: 4];
        msd   = -1;
        for (int i = 0; i < N; i++) begin
            if (sh_en[i] && sh_dg[4*i +: 4] != 4'h0) msd = i;
        end
        shown = (ph >= BL) && sh_en[slot];
`ifdef SSD_LZ_BLANK_EN
        if (slot > 0 && slot > msd) shown = 0;
`endif
        e_an  = shown ? ~(4'b0001 << slot) : 4'hF;
        e_seg = shown ? seg_code(nib) : 7'h7F;
        e_dp  = shown ? ~sh_dp[slot] : 1'b1;
        e_fd  = ((t % FR) == FR - 1);
        if (ld) begin
            pd_dg = dg;
            pd_dp = dp;
            pd_en = en;
            pv    = 1;
        end
        if ((t % FR) == FR - 1) begin
            if (ld) begin
                sh_dg = dg;
                sh_dp = dp;
                sh_en = en;
            end else if (pv) begin
                sh_dg = pd_dg;
                sh_dp = pd_dp;
                sh_en = pd_en;
            end
            pv = 0;
        end
        t++;
        @(posedge clk);
        #1;
        check("an_out", 32'(an_out), 32'(e_an));
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("dp_out", 32'(dp_out), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        for (int i = 0; i < 4; i++) if (an_out[i] == 1'b0) lit[i]++;
        if (frame_done) fd_seen.push_back(t);
        if (an_out != 4'hF && seg_out == seg_code(4'hA)) seen_a = 1;
        if (an_out != 4'hF && seg_out == seg_code(4'h5)) seen_5 = 1;
    endtask

    task automatic run_to(input int target);
        while (t < target) step(0, '0, '0, '0);
    endtask

    // Called just after a rising edge; holds reset for one cycle.
    task automatic do_reset();
        load    = 0;
        reset_n = 0;
        #1;
        check("rst_an", 32'(an_out), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
        clear_tallies();
    endtask

    initial begin
        int target;
        reset_n     = 1;
        load        = 0;
        digits_in   = '0;
        dp_in       = '0;
        digit_en_in = '0;
        model_reset();
        #2;
        do_reset();

        // Idle after reset: dark display, frame_done at cycles 32 and 64.
        run_to(64);
        check("idle_fd_count", 32'(fd_seen.size()), 32'd2);
        check("idle_fd_first", 32'(fd_seen[0]), 32'd32);
        check("idle_fd_second", 32'(fd_seen[1]), 32'd64);
        check("idle_lit", 32'(lit[0] + lit[1] + lit[2] + lit[3]), 32'd0);

        // Mid-frame load is held until the next boundary.
        run_to(74);
        clear_tallies();
        step(1, 16'h1234, 4'b0001, 4'hF);
        run_to(96);
        check("pre_boundary_lit", 32'(lit[0] + lit[1] + lit[2] + lit[3]), 32'd0);
        clear_tallies();
        run_to(100);
        check("d0_an", 32'(an_out), 32'b1110);
        check("d0_seg", 32'(seg_out), 32'h4C);
        check("d0_dp", 32'(dp_out), 32'd0);
        run_to(110);
        check("d1_an", 32'(an_out), 32'b1101);
        check("d1_seg", 32'(seg_out), 32'h06);
        run_to(128);
        for (int i = 0; i < 4; i++) check("lit_per_slot", 32'(lit[i]), 32'(SD - BL));

        // Two loads in one frame: only the last reaches the display.
        clear_tallies();
        run_to(133);
        step(1, 16'hAAAA, 4'h0, 4'hF);
        run_to(148);
        step(1, 16'h5555, 4'h0, 4'hF);
        run_to(192);
        check("first_load_never_shown", 32'(seen_a), 32'd0);
        check("last_load_shown", 32'(seen_5), 32'd1);

        // Load coincident with the boundary goes straight to the display.
        run_to(223);
        step(1, 16'hBEEF, 4'h0, 4'hF);
        run_to(226);
        check("beef_blank", 32'(an_out), 32'hF);
        step(0, '0, '0, '0);
        check("beef_an", 32'(an_out), 32'b1110);
        check("beef_seg", 32'(seg_out), 32'h38);

        // Zero-valued upper digits.
        run_to(250);
        step(1, 16'h0070, 4'h0, 4'hF);
        run_to(256);
        clear_tallies();
        run_to(288);
`ifdef SSD_LZ_BLANK_EN
        check("lz_d3", 32'(lit[3]), 32'd0);
        check("lz_d2", 32'(lit[2]), 32'd0);
`else
        check("lz_d3", 32'(lit[3]), 32'(SD - BL));
        check("lz_d2", 32'(lit[2]), 32'(SD - BL));
`endif
        check("lz_d1", 32'(lit[1]), 32'(SD - BL));
        check("lz_d0", 32'(lit[0]), 32'(SD - BL));

        // Random loads at random times.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(15) == 0) begin
                step(1, 16'($urandom), 4'($urandom), 4'($urandom));
            end else begin
                step(0, 16'($urandom), 4'($urandom), 4'($urandom));
            end
        end

        // Reset while digit 2 is lit.
        step(1, 16'h1234, 4'h0, 4'hF);
        target = (t / FR + 1) * FR + 2 * SD + 5;
        run_to(target);
        check("pre_reset_an", 32'(an_out), 32'b1011);
        check("pre_reset_seg", 32'(seg_out), 32'h12);
        do_reset();
        run_to(70);
        check("post_reset_lit", 32'(lit[0] + lit[1] + lit[2] + lit[3]), 32'd0);
        check("post_reset_fd_count", 32'(fd_seen.size()), 32'd2);
        check("post_reset_fd_first", 32'(fd_seen[0]), 32'd32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
